// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - Default address/data widths (ADDR_LEN / DATA_LEN).
//   - Port index constants (PORT_DATA, PORT_FETCH).
//   - FSM state encoding and starvation-counter width.
//   - port_onehot(): converts a port index into a 2-bit one-hot mask.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned DATA_LEN = 32;

    localparam int unsigned PORT_DATA  = 0;
    localparam int unsigned PORT_FETCH = 1;

    // Wide enough for the full legal STARVE_LIMIT range of 1..15.
    localparam int unsigned STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational arbitration decision for the two-port memory arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin (rr_ptr input) instead of
// fixed priority with a starvation counter (starve_cnt input).
// Ports:
//   req_valid   in  2   per-port request valid (bit0 = data, bit1 = fetch)
//   rr_ptr      in  1   preferred port when both are valid (round-robin build)
//   starve_cnt  in  4   consecutive lost arbitrations of port 1 (fixed build)
//   grant       out 2   one-hot winner, 0 when nothing is valid
module mem_arb_pick
    import mem_arbiter_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
    parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
    input  logic [1:0]              req_valid,
`ifdef MEM_ARB_RR_EN
    input  logic                    rr_ptr,
`else
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
`endif
    output logic [1:0]              grant
);

`ifndef MEM_ARB_RR_EN
    localparam logic [STARVE_CNT_W-1:0] LimitC = STARVE_CNT_W'(STARVE_LIMIT);
`endif

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
`ifdef MEM_ARB_RR_EN
                grant = port_onehot(rr_ptr);
`else
                // Data port normally wins; fetch is let through once starved.
                grant = (starve_cnt == LimitC) ? 2'b10 : 2'b01;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-ported memory datapath.
// Port 0 = data (load/store stage), port 1 = instruction fetch. One transaction
// at a time: accept (IDLE) -> memory access (ACCESS) -> response pulse (RESP).
// Build option: MEM_ARB_RR_EN selects round-robin arbitration; when undefined,
// fixed priority to port 0 with a starvation counter for port 1.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      2-bit per-port handshake, ready is one-hot or 0
//   req_we                   2-bit per-port write flag
//   req_addr0/1, req_wdata0/1  per-port address / write data
//   rsp_valid                one-cycle pulse to the owning port
//   rsp_rdata                read data (0 for writes), held until next access
//   mem_wen/waddr/wdata/raddr  memory drive, non-zero only during ACCESS
//   mem_rdata                combinational read data from memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_LEN,
    parameter int unsigned DATA_W       = DATA_LEN,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        grant;
    logic              xfer;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    mem_arb_pick u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant)
    );
`else
    localparam logic [STARVE_CNT_W-1:0] LimitC = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .req_valid  (req_valid),
        .starve_cnt (starve_cnt_q),
        .grant      (grant)
    );
`endif

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign req_ready = (state_q == StIdle && !rst) ? grant : 2'b00;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        owner_d = owner_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    owner_d = grant[PORT_FETCH];
                    if (grant[PORT_FETCH]) begin
                        addr_d  = req_addr1;
                        wdata_d = req_wdata1;
                        we_d    = req_we[PORT_FETCH];
                    end else begin
                        addr_d  = req_addr0;
                        wdata_d = req_wdata0;
                        we_d    = req_we[PORT_DATA];
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                rdata_d = we_q ? '0 : mem_rdata;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef MEM_ARB_RR_EN
    // After each transfer the loser becomes the preferred port.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = ~grant[PORT_FETCH];
        end
    end
`else
    // Counts IDLE cycles in which fetch was valid but lost; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == StIdle) begin
            if (grant[PORT_FETCH]) begin
                starve_cnt_d = '0;
            end else if (req_valid[PORT_FETCH] && starve_cnt_q < LimitC) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    always_comb begin
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_raddr = '0;
        rsp_valid = 2'b00;
        if (state_q == StAccess) begin
            mem_wen   = we_q;
            mem_waddr = addr_q;
            mem_wdata = wdata_q;
            mem_raddr = addr_q;
        end
        if (state_q == StResp) begin
            rsp_valid = port_onehot(owner_q);
        end
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [31:0] rsp_rdata, mem_waddr, mem_wdata, mem_raddr, mem_rdata;
    logic        mem_wen;

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory wrapper stand-in: combinational read, written by the bench process.
    logic [31:0] tb_mem [256];
    assign mem_rdata = tb_mem[mem_raddr[7:0]];

    // Reference model state (transaction level).
    logic [31:0] ref_mem [256];
    int          m_busy;       // cycles since accept: 0 = free, 1 = access, 2 = response
    logic        m_owner, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_cnt;
    logic        m_ptr;

    // Requester state.
    logic [1:0]  p_pend, p_we;
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];

    int unsigned n_vec = 0, n_err = 0;
    int          cyc = 0, wen_cnt = 0;
    int          grants[$];
    int          accepts[$];
    logic [1:0]  last_ready, last_rsp;
    logic [31:0] last_raddr, last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_winner(input logic [1:0] v);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef MEM_ARB_RR_EN
        return int'(m_ptr);
`else
        return (m_cnt >= LIMIT) ? 1 : 0;
`endif
    endfunction

    task automatic arm(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        p_pend[i]  = 1'b1;
        p_we[i]    = we;
        p_addr[i]  = a;
        p_wdata[i] = d;
    endtask

    task automatic arm_random(input int i);
        arm(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_cnt   = 0;
        m_ptr   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
        chk({tag, "_mem_raddr"}, mem_raddr, 32'd0);
        chk({tag, "_mem_waddr"}, mem_waddr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // One clock cycle: drive at negedge, check mid-low phase, advance model.
    task automatic step();
        int          w;
        logic [1:0]  exp_ready, exp_rsp;
        logic [31:0] exp_a, exp_d;
        req_valid  = p_pend;
        req_we     = p_we;
        req_addr0  = p_addr[0];
        req_addr1  = p_addr[1];
        req_wdata0 = p_wdata[0];
        req_wdata1 = p_wdata[1];
        #2;
        w = -1;
        exp_ready = 2'b00;
        exp_rsp = 2'b00;
        if (m_busy == 0) begin
            w = ref_winner(p_pend);
            if (w == 0) exp_ready = 2'b01;
            if (w == 1) exp_ready = 2'b10;
        end
        if (m_busy == 2) exp_rsp = m_owner ? 2'b10 : 2'b01;
        exp_a = (m_busy == 1) ? m_addr : 32'd0;
        exp_d = (m_busy == 1) ? m_wdata : 32'd0;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("mem_wen", 32'(mem_wen), 32'((m_busy == 1) && m_we));
        chk("mem_raddr", mem_raddr, exp_a);
        chk("mem_waddr", mem_waddr, exp_a);
        chk("mem_wdata", mem_wdata, exp_d);
        last_ready = req_ready;
        last_rsp   = rsp_valid;
        last_raddr = mem_raddr;
        last_rdata = rsp_rdata;
        if (mem_wen) begin
            tb_mem[mem_waddr[7:0]] = mem_wdata;
            wen_cnt++;
        end
        case (m_busy)
            0: if (w >= 0) begin
                m_owner = w[0];
                m_we    = p_we[w];
                m_addr  = p_addr[w];
                m_wdata = p_wdata[w];
                m_busy  = 1;
                grants.push_back(w);
                accepts.push_back(cyc);
                if (w == 1) m_cnt = 0;
                else if (p_pend[1]) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
                m_ptr = (w == 0);
                p_pend[w] = 1'b0;
            end
            1: begin
                m_rdata = m_we ? 32'd0 : ref_mem[m_addr[7:0]];
                if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                m_busy = 2;
            end
            default: m_busy = 0;
        endcase
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        p_pend = 2'b00;
        p_we   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            p_addr[i]  = '0;
            p_wdata[i] = '0;
        end
        rst        = 1'b1;
        req_valid  = 2'b11;
        req_we     = 2'b00;
        req_addr0  = '0;
        req_addr1  = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;

        // Reset state, with requests pending so ready gating is exercised.
        @(negedge clk);
        @(negedge clk);
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Port 0 load from a preloaded location.
        tb_mem[8'h10]  = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;
        arm(0, 1'b0, 32'h10, 32'h0);
        step();
        chk("t1_ready", 32'(last_ready), 32'h1);
        step();
        chk("t1_raddr", last_raddr, 32'h10);
        step();
        chk("t1_rsp_valid", 32'(last_rsp), 32'h1);
        chk("t1_rsp_rdata", last_rdata, 32'hDEADBEEF);

        // Port 1 store followed by port 0 load of the same address.
        wen_cnt = 0;
        arm(1, 1'b1, 32'h20, 32'h12345678);
        repeat (3) step();
        chk("t2_store_rsp", 32'(last_rsp), 32'h2);
        chk("t2_store_rdata", last_rdata, 32'h0);
        arm(0, 1'b0, 32'h20, 32'h0);
        repeat (3) step();
        chk("t2_wen_cycles", 32'(wen_cnt), 32'd1);
        chk("t2_load_rdata", last_rdata, 32'h12345678);

        // Both ports valid continuously.
        grants.delete();
        accepts.delete();
        for (int k = 0; k < 30; k++) begin
            if (!p_pend[0]) arm_random(0);
            if (!p_pend[1]) arm_random(1);
            step();
        end
        chk("t3_grant_count", 32'(grants.size()), 32'd10);
        for (int i = 0; i < grants.size() && i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
            // Previous transfer went to port 0, so port 1 is preferred first.
            chk($sformatf("t3_grant%0d", i), 32'(grants[i]), 32'((i + 1) % 2));
`else
            chk($sformatf("t3_grant%0d", i), 32'(grants[i]),
                32'((i % (LIMIT + 1)) == LIMIT));
`endif
        end
        for (int i = 1; i < accepts.size(); i++) begin
            chk($sformatf("t3_spacing%0d", i), 32'(accepts[i] - accepts[i-1]), 32'd3);
        end
        p_pend = 2'b00;
        while (m_busy != 0) step();

        // Reset asserted during ACCESS of a port 1 load.
        arm(1, 1'b0, 32'h30, 32'h0);
        step();
        req_valid = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        #2;
        chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_hold_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        arm(0, 1'b0, 32'h30, 32'h0);
        step();
        chk("rst_next_ready", 32'(last_ready), 32'h1);
        repeat (2) step();
        chk("rst_next_rsp", 32'(last_rsp), 32'h1);

        // Random traffic, including requests withdrawn before acceptance.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_pend[i] && $urandom_range(0, 3) == 0) arm_random(i);
                else if (p_pend[i] && $urandom_range(0, 15) == 0) p_pend[i] = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
